// File: rtl/arbiter_game_pkg.sv
// Shared types and encodings for the arbiter game input conditioner.
package arbiter_game_pkg;

    // First-press latch states
    typedef enum logic {
        ST_ARMED  = 1'b0,
        ST_LOCKED = 1'b1
    } fsm_state_t;

    // first_id encodings
    localparam logic [1:0] ID_NONE = 2'b00;
    localparam logic [1:0] ID_P1   = 2'b01;
    localparam logic [1:0] ID_P2   = 2'b10;
    localparam logic [1:0] ID_TIE  = 2'b11;

    // Maps the pair of effective presses seen in one cycle to a result code.
    function automatic logic [1:0] first_id_of(input logic p1, input logic p2);
        logic [1:0] id;
        id = ID_NONE;
        if (p1 && p2) begin
            id = ID_TIE;
        end else if (p1) begin
            id = ID_P1;
        end else if (p2) begin
            id = ID_P2;
        end
        return id;
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One push-button channel: synchronizer chain, debounce counter, press
// pulse and, when ARB_STUCK_DETECT_EN is defined, a stuck-button detector.
// Without ARB_STUCK_DETECT_EN the stuck output is tied low.
module debounce_channel
    import arbiter_game_pkg::*;
#(
    parameter int DEBOUNCE_COUNT = 20,
    parameter int SYNC_STAGES    = 2,
    parameter int STUCK_COUNT    = 4000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_n,
    output logic level,
    output logic press,
    output logic stuck
);

    localparam int CW = $clog2(DEBOUNCE_COUNT);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_COUNT - 1);

    if (DEBOUNCE_COUNT < 2 || DEBOUNCE_COUNT > 65535 || SYNC_STAGES < 2 || STUCK_COUNT < 1) begin : g_param_check
        $error("debounce_channel: illegal parameter value");
    end

    logic [SYNC_STAGES-1:0] sync;
    logic [CW-1:0]          cnt;
    logic                   sample;
    logic                   accept;
    logic                   falling;

    // Synchronizer chain; resets to released so nothing is seen as pressed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= '1;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], btn_n};
        end
    end

    assign sample  = ~sync[SYNC_STAGES-1];
    assign accept  = (sample != level) && (cnt == CNT_LAST);
    assign falling = accept && !sample;

    // Debounce: a new level must persist for DEBOUNCE_COUNT cycles; any
    // return to the current level restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            level <= 1'b0;
            press <= 1'b0;
        end else begin
            press <= accept && sample;
            if (sample == level) begin
                cnt <= '0;
            end else if (accept) begin
                level <= sample;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

`ifdef ARB_STUCK_DETECT_EN
    localparam int HW = $clog2(STUCK_COUNT + 1);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(STUCK_COUNT);
    localparam logic [HW-1:0] HOLD_LAST = HW'(STUCK_COUNT - 1);

    logic [HW-1:0] hold;
    logic          stuck_q;

    // Hold counter: counts cycles with level high, saturating; flag clears
    // on the same edge the level falls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold    <= '0;
            stuck_q <= 1'b0;
        end else if (!level || falling) begin
            hold    <= '0;
            stuck_q <= 1'b0;
        end else begin
            if (hold != HOLD_MAX) begin
                hold <= hold + 1'b1;
            end
            stuck_q <= (hold >= HOLD_LAST);
        end
    end

    assign stuck = stuck_q;
`else
    assign stuck = 1'b0;
`endif

endmodule

// File: rtl/arbiter_input_conditioner.sv
// Front end for the two player buttons: two debounce channels plus the
// first-press latch. Stuck detection is built in only with
// ARB_STUCK_DETECT_EN; otherwise stuck_out reads 00 and presses are unmasked.
//
// state     | meaning
// ST_ARMED  | waiting for the first debounced press
// ST_LOCKED | result latched, further presses ignored until clear_in
module arbiter_input_conditioner
    import arbiter_game_pkg::*;
#(
    parameter int DEBOUNCE_COUNT = 20,
    parameter int SYNC_STAGES    = 2,
    parameter int STUCK_COUNT    = 4000
) (
    input  logic       clk,
    input  logic       rst_in_n,
    input  logic       btn1_in_n,
    input  logic       btn2_in_n,
    input  logic       clear_in,
    output logic       req1_out,
    output logic       req2_out,
    output logic       press1_out,
    output logic       press2_out,
    output logic       first_valid_out,
    output logic [1:0] first_id_out,
    output logic [1:0] stuck_out
);

    fsm_state_t state;
    logic       stuck1;
    logic       stuck2;
    logic       arm1;
    logic       arm2;

    debounce_channel #(
        .DEBOUNCE_COUNT (DEBOUNCE_COUNT),
        .SYNC_STAGES    (SYNC_STAGES),
        .STUCK_COUNT    (STUCK_COUNT)
    ) u_ch1 (
        .clk   (clk),
        .rst_n (rst_in_n),
        .btn_n (btn1_in_n),
        .level (req1_out),
        .press (press1_out),
        .stuck (stuck1)
    );

    debounce_channel #(
        .DEBOUNCE_COUNT (DEBOUNCE_COUNT),
        .SYNC_STAGES    (SYNC_STAGES),
        .STUCK_COUNT    (STUCK_COUNT)
    ) u_ch2 (
        .clk   (clk),
        .rst_n (rst_in_n),
        .btn_n (btn2_in_n),
        .level (req2_out),
        .press (press2_out),
        .stuck (stuck2)
    );

    assign stuck_out = {stuck2, stuck1};

    // A stuck channel cannot claim the latch; stuck is constant 0 when the
    // detector is not built.
    assign arm1 = press1_out && !stuck1;
    assign arm2 = press2_out && !stuck2;

    // First-press latch; clear_in wins over a press in the same cycle.
    always_ff @(posedge clk or negedge rst_in_n) begin
        if (!rst_in_n) begin
            state           <= ST_ARMED;
            first_valid_out <= 1'b0;
            first_id_out    <= ID_NONE;
        end else if (clear_in) begin
            state           <= ST_ARMED;
            first_valid_out <= 1'b0;
            first_id_out    <= ID_NONE;
        end else begin
            case (state)
                ST_ARMED: begin
                    if (arm1 || arm2) begin
                        state           <= ST_LOCKED;
                        first_valid_out <= 1'b1;
                        first_id_out    <= first_id_of(arm1, arm2);
                    end
                end
                ST_LOCKED: begin
                    state <= ST_LOCKED;
                end
                default: begin
                    state           <= ST_ARMED;
                    first_valid_out <= 1'b0;
                    first_id_out    <= ID_NONE;
                end
            endcase
        end
    end

endmodule
